// File: rtl/uart_word_pack_reg_pkg.sv
// Shared definitions for the UART byte-to-word packer: FSM encoding, width
// helper and default configuration constants.
package uart_pack_pkg;

   localparam int unsigned DEF_BYTE_W      = 8;
   localparam int unsigned DEF_NUM_BYTES   = 4;
   localparam int unsigned DEF_TIMEOUT_CYC = 1024;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } pack_state_e;

   function automatic int unsigned word_w(input int unsigned byte_w,
                                          input int unsigned num_bytes);
      return byte_w * num_bytes;
   endfunction

endpackage

// File: rtl/uart_word_pack_reg_if.sv
// Byte-in / word-out handshake bundle of the UART word packer. The master
// side is the UART RX plus DDR write consumer; the slave side is the packer.
interface uart_pack_if
   import uart_pack_pkg::*;
#(
   parameter int unsigned BYTE_W    = DEF_BYTE_W,
   parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
   parameter int unsigned CNT_W     = $clog2(NUM_BYTES + 1)
);
   localparam int unsigned WORD_W = word_w(BYTE_W, NUM_BYTES);

   logic [BYTE_W-1:0] i_data;
   logic              i_enable;
   logic [WORD_W-1:0] o_word;
   logic              o_valid;
   logic              i_ready;
   logic [CNT_W-1:0]  o_nbytes;
   logic              o_partial;
   logic [CNT_W-1:0]  o_count;
   logic              o_overflow;

   modport master (
      output i_data, i_enable, i_ready,
      input  o_word, o_valid, o_nbytes, o_partial, o_count, o_overflow
   );

   modport slave (
      input  i_data, i_enable, i_ready,
      output o_word, o_valid, o_nbytes, o_partial, o_count, o_overflow
   );

endinterface

// File: rtl/uart_word_pack_reg_timer.sv
// Saturating idle counter: counts while enabled, clears on request, and
// flags expiry once it sits at LIMIT.
module uart_pack_timer #(
   parameter int unsigned LIMIT = 1024,
   parameter int unsigned W     = $clog2(LIMIT + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clear)
         cnt_d = '0;
      else if (i_enable && (cnt_q != W'(LIMIT)))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign o_expired = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/uart_word_pack_reg.sv
// Packs NUM_BYTES UART bytes into one word with a double-buffered valid/ready
// output. Define PACK_TIMEOUT_EN to flush partial words after idle time.
module uart_word_pack_reg
   import uart_pack_pkg::*;
#(
   parameter int unsigned BYTE_W    = DEF_BYTE_W,
   parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
   parameter int unsigned CNT_W     = $clog2(NUM_BYTES + 1)
`ifdef PACK_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
   input  logic        i_clk,
   input  logic        i_rst,
   uart_pack_if.slave  bus
);

   localparam int unsigned      WORD_W = word_w(BYTE_W, NUM_BYTES);
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(NUM_BYTES);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(NUM_BYTES - 1);

   pack_state_e       state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  nbytes_q, nbytes_d;
   logic              partial_q, partial_d;
   logic              overflow_q, overflow_d;

   logic              slot_free;
   logic              flush_now;
   logic [WORD_W-1:0] merged;

   assign slot_free = !valid_q || bus.i_ready;

`ifdef PACK_TIMEOUT_EN
   logic expired;

   uart_pack_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (bus.i_enable || flush_now || (state_q != ACC)),
      .i_enable  ((state_q == ACC) && (count_q != '0)),
      .o_expired (expired)
   );

   assign flush_now = (state_q == ACC) && (count_q != '0) && expired && slot_free;
`else
   assign flush_now = 1'b0;
`endif

   // Accumulator with the incoming byte dropped into the lane selected by count.
   always_comb begin
      merged = acc_q;
      for (int k = 0; k < NUM_BYTES; k++)
         if (count_q == CNT_W'(k))
            merged[k*BYTE_W +: BYTE_W] = bus.i_data;
   end

   // NOTE: every _d takes its hold value first, so no branch can infer a latch.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_d      = acc_q;
      word_d     = word_q;
      valid_d    = valid_q && !bus.i_ready;
      nbytes_d   = nbytes_q;
      partial_d  = partial_q;
      overflow_d = 1'b0;

      case (state_q)
         ACC: begin
            if (flush_now) begin
               word_d    = acc_q;
               valid_d   = 1'b1;
               nbytes_d  = count_q;
               partial_d = 1'b1;
               acc_d     = bus.i_enable ? WORD_W'(bus.i_data) : '0;
               count_d   = bus.i_enable ? CNT_W'(1) : '0;
            end else if (bus.i_enable) begin
               if (count_q != LAST) begin
                  acc_d   = merged;
                  count_d = count_q + 1'b1;
               end else if (slot_free) begin
                  word_d    = merged;
                  valid_d   = 1'b1;
                  nbytes_d  = FULL;
                  partial_d = 1'b0;
                  acc_d     = '0;
                  count_d   = '0;
               end else begin
                  acc_d   = merged;
                  count_d = FULL;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (slot_free) begin
               word_d    = acc_q;
               valid_d   = 1'b1;
               nbytes_d  = FULL;
               partial_d = 1'b0;
               acc_d     = bus.i_enable ? WORD_W'(bus.i_data) : '0;
               count_d   = bus.i_enable ? CNT_W'(1) : '0;
               state_d   = ACC;
            end else if (bus.i_enable) begin
               overflow_d = 1'b1;
            end
         end
         default: state_d = ACC;
      endcase
   end

   // NOTE: registers update with <= only, so every reader sees the pre-edge value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ACC;
         count_q    <= '0;
         acc_q      <= '0;
         word_q     <= '0;
         valid_q    <= 1'b0;
         nbytes_q   <= '0;
         partial_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         word_q     <= word_d;
         valid_q    <= valid_d;
         nbytes_q   <= nbytes_d;
         partial_q  <= partial_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.o_word     = word_q;
   assign bus.o_valid    = valid_q;
   assign bus.o_nbytes   = nbytes_q;
   assign bus.o_partial  = partial_q;
   assign bus.o_count    = count_q;
   assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_word_pack_reg.sv
// Bench for uart_word_pack_reg: directed vector table, reset and idle
// sequences, then random traffic against a queue-based packing model.
module tb_uart_word_pack_reg;
   import uart_pack_pkg::*;

   localparam int BYTE_W    = 8;
   localparam int NUM_BYTES = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_pack_if #(.BYTE_W(BYTE_W), .NUM_BYTES(NUM_BYTES)) bus ();

`ifdef PACK_TIMEOUT_EN
   uart_word_pack_reg #(.BYTE_W(BYTE_W), .NUM_BYTES(NUM_BYTES), .TIMEOUT_CYC(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );
`else
   uart_word_pack_reg #(.BYTE_W(BYTE_W), .NUM_BYTES(NUM_BYTES)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );
`endif

   typedef struct {
      logic        en;
      logic [7:0]  data;
      logic        rdy;
      logic        exp_valid;
      logic [31:0] exp_word;
      logic [2:0]  exp_count;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step(input logic en, input logic [7:0] d, input logic rdy);
      bus.i_enable = en;
      bus.i_data   = d;
      bus.i_ready  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
   endtask

   function automatic void add(input logic en, input logic [7:0] d, input logic rdy,
                               input logic v, input logic [31:0] w, input logic [2:0] c,
                               input logic o);
      vec_t t;
      t.en = en; t.data = d; t.rdy = rdy;
      t.exp_valid = v; t.exp_word = w; t.exp_count = c; t.exp_ovf = o;
      vecs.push_back(t);
   endfunction

   function automatic logic [31:0] pack(input logic [7:0] q[$]);
      logic [31:0] w = '0;
      for (int i = 0; i < q.size(); i++) w = w | (32'(q[i]) << (8 * i));
      return w;
   endfunction

   initial begin
      logic [7:0]  acc_m[$];
      logic        m_valid, m_ovf, free, seen, en, rdy;
      logic [31:0] m_word;
      logic [7:0]  d;

      bus.i_enable = 1'b0;
      bus.i_data   = '0;
      bus.i_ready  = 1'b0;
      rst          = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      do_reset();

      check("reset.valid",    bus.o_valid,    0);
      check("reset.word",     bus.o_word,     0);
      check("reset.count",    bus.o_count,    0);
      check("reset.nbytes",   bus.o_nbytes,   0);
      check("reset.partial",  bus.o_partial,  0);
      check("reset.overflow", bus.o_overflow, 0);

      // en, data, ready -> valid, word, count, overflow after the edge
      add(1, 8'h11, 1, 0, 32'h0,        1, 0);
      add(1, 8'h22, 1, 0, 32'h0,        2, 0);
      add(1, 8'h33, 1, 0, 32'h0,        3, 0);
      add(1, 8'h44, 1, 1, 32'h44332211, 0, 0);
      add(0, 8'h00, 1, 0, 32'h0,        0, 0);
      add(1, 8'hA0, 0, 0, 32'h0,        1, 0);
      add(1, 8'hA1, 0, 0, 32'h0,        2, 0);
      add(1, 8'hA2, 0, 0, 32'h0,        3, 0);
      add(1, 8'hA3, 0, 1, 32'hA3A2A1A0, 0, 0);
      add(1, 8'hB0, 0, 1, 32'hA3A2A1A0, 1, 0);
      add(1, 8'hB1, 0, 1, 32'hA3A2A1A0, 2, 0);
      add(1, 8'hB2, 0, 1, 32'hA3A2A1A0, 3, 0);
      add(1, 8'hB3, 0, 1, 32'hA3A2A1A0, 4, 0);
      add(1, 8'hCC, 0, 1, 32'hA3A2A1A0, 4, 1);
      add(0, 8'h00, 0, 1, 32'hA3A2A1A0, 4, 0);
      add(0, 8'h00, 1, 1, 32'hB3B2B1B0, 0, 0);
      add(1, 8'hC0, 0, 1, 32'hB3B2B1B0, 1, 0);
      add(1, 8'hC1, 0, 1, 32'hB3B2B1B0, 2, 0);
      add(1, 8'hC2, 0, 1, 32'hB3B2B1B0, 3, 0);
      add(1, 8'hC3, 0, 1, 32'hB3B2B1B0, 4, 0);
      add(1, 8'h5A, 1, 1, 32'hC3C2C1C0, 1, 0);
      add(1, 8'h5B, 0, 1, 32'hC3C2C1C0, 2, 0);
      add(1, 8'h5C, 0, 1, 32'hC3C2C1C0, 3, 0);
      add(1, 8'h5D, 0, 1, 32'hC3C2C1C0, 4, 0);
      add(0, 8'h00, 1, 1, 32'h5D5C5B5A, 0, 0);
      add(0, 8'h00, 1, 0, 32'h0,        0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].data, vecs[i].rdy);
         check($sformatf("vec%0d.valid", i), bus.o_valid,    vecs[i].exp_valid);
         check($sformatf("vec%0d.count", i), bus.o_count,    vecs[i].exp_count);
         check($sformatf("vec%0d.ovf", i),   bus.o_overflow, vecs[i].exp_ovf);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d.word", i),   bus.o_word,   vecs[i].exp_word);
            check($sformatf("vec%0d.nbytes", i), bus.o_nbytes, 4);
         end
      end

      // Reset mid-word with an output pending: everything discarded.
      for (int i = 0; i < 4; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0);
      step(1'b1, 8'hF0, 1'b0);
      step(1'b1, 8'hF1, 1'b0);
      check("prerst.valid", bus.o_valid, 1);
      check("prerst.count", bus.o_count, 2);
      do_reset();
      check("midrst.valid",  bus.o_valid,  0);
      check("midrst.count",  bus.o_count,  0);
      check("midrst.word",   bus.o_word,   0);
      check("midrst.nbytes", bus.o_nbytes, 0);
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1);
      check("postrst.valid", bus.o_valid, 1);
      check("postrst.word",  bus.o_word,  32'h04030201);
      step(1'b0, 8'h00, 1'b1);

      // Two bytes then idle: a flush only exists with the timeout feature.
      step(1'b1, 8'h01, 1'b1);
      step(1'b1, 8'h02, 1'b1);
      seen = 1'b0;
`ifdef PACK_TIMEOUT_EN
      for (int i = 0; i < 40 && !seen; i++) begin
         step(1'b0, 8'h00, 1'b1);
         if (bus.o_valid) seen = 1'b1;
      end
      check("flush.seen",    seen,          1);
      check("flush.word",    bus.o_word,    32'h00000201);
      check("flush.nbytes",  bus.o_nbytes,  2);
      check("flush.partial", bus.o_partial, 1);
      check("flush.count",   bus.o_count,   0);
`else
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 8'h00, 1'b1);
         if (bus.o_valid) seen = 1'b1;
      end
      check("idle.no_output", seen,          0);
      check("idle.count",     bus.o_count,   2);
      check("idle.partial",   bus.o_partial, 0);
`endif

      // Random traffic against the queue model.
      do_reset();
      acc_m.delete();
      m_valid = 1'b0;
      m_word  = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         en  = ($urandom_range(0, 9) < 6);
         rdy = $urandom_range(0, 1) == 1;
         d   = 8'($urandom);
         free    = !m_valid || rdy;
         m_ovf   = 1'b0;
         m_valid = m_valid && !rdy;
         if (acc_m.size() == NUM_BYTES) begin
            if (free) begin
               m_word  = pack(acc_m);
               m_valid = 1'b1;
               acc_m.delete();
               if (en) acc_m.push_back(d);
            end else if (en) begin
               m_ovf = 1'b1;
            end
         end else if (en) begin
            acc_m.push_back(d);
            if (acc_m.size() == NUM_BYTES && free) begin
               m_word  = pack(acc_m);
               m_valid = 1'b1;
               acc_m.delete();
            end
         end
         step(en, d, rdy);
         check($sformatf("rnd%0d.valid", cyc), bus.o_valid,    m_valid);
         check($sformatf("rnd%0d.count", cyc), bus.o_count,    acc_m.size());
         check($sformatf("rnd%0d.ovf", cyc),   bus.o_overflow, m_ovf);
         if (m_valid) begin
            check($sformatf("rnd%0d.word", cyc),   bus.o_word,   m_word);
            check($sformatf("rnd%0d.nbytes", cyc), bus.o_nbytes, NUM_BYTES);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_word_pack_reg.md
Name: uart_word_pack_reg

Overview:
Parametrised successor to the single-byte UART holding register. It packs NUM_BYTES consecutive UART bytes into one WORD_W-bit word for the DDR write path and presents the word on a valid/ready output. A double-buffered accumulator and output register let the next word keep filling while the downstream side stalls. It sits between the UART RX FSM and the DDR write-data FIFO/controller.

Parameters:
BYTE_W, 8, width of one UART byte lane
NUM_BYTES, 4, bytes per packed word (>=2); WORD_W = BYTE_W*NUM_BYTES
CNT_W, $clog2(NUM_BYTES+1), width of byte-count fields
TIMEOUT_CYC, 1024, idle cycles before a partial-word flush (used only with PACK_TIMEOUT_EN)

Ports:
i_clk  in  1  single clock; all logic on posedge
i_rst  in  1  synchronous, active-high reset
i_data  in  BYTE_W  incoming UART byte
i_enable  in  1  byte strobe; i_data is valid this cycle
o_word  out  WORD_W  packed word; first byte in bits [BYTE_W-1:0]
o_valid  out  1  o_word valid; held until accepted
i_ready  in  1  downstream accepts o_word when o_valid&&i_ready
o_nbytes  out  CNT_W  number of valid bytes in o_word (NUM_BYTES unless partial)
o_partial  out  1  o_word is a timeout flush (upper lanes zero)
o_count  out  CNT_W  bytes currently held in the accumulator
o_overflow  out  1  one-cycle pulse: byte dropped

Behaviour:
- Reset (i_rst=1 at posedge): accumulator, count, state, timer cleared; o_word=0, o_valid=0, o_nbytes=0, o_partial=0, o_count=0, o_overflow=0. Reset mid-word discards the partial word and any pending output with no flush.
- Lane mapping: the k-th accepted byte (k=0..NUM_BYTES-1) writes acc[k*BYTE_W +: BYTE_W]. Unwritten lanes read as zero and are cleared on every transfer.
- "Slot free" this cycle = !o_valid || i_ready.
- FSM states: ACC (filling, count < NUM_BYTES) and HOLD (accumulator full, output slot busy).
- ACC, i_enable, count < NUM_BYTES-1: store byte, count+1.
- ACC, i_enable completing the word, slot free: merged word loads o_word the same edge. o_valid=1 and o_nbytes=NUM_BYTES the next cycle (latency 1 from the last byte strobe). Count returns to 0; stay in ACC.
- ACC, i_enable completing the word, slot busy: store byte, count=NUM_BYTES, go to HOLD.
- HOLD, slot frees (handshake): accumulator transfers to o_word on that edge, o_valid stays 1, count=0, go to ACC. If i_enable is also high that cycle, the byte is accepted as byte 0 of the next word (count=1).
- HOLD, i_enable without handshake: byte dropped; o_overflow=1 for exactly the next cycle; accumulator unchanged.
- Output: handshake with nothing to transfer clears o_valid the next cycle. o_word is stable while o_valid=1 and not accepted.
- o_count reflects the registered accumulator count.

Optional Feature:
Macro PACK_TIMEOUT_EN.
- Defined: a timer counts cycles in ACC with count>0 and no i_enable; it resets on every accepted byte. When it reaches TIMEOUT_CYC and the slot is free, the partial word transfers to the output with o_partial=1 and o_nbytes=count. Count is cleared and the timer is cleared. If the slot is busy, the flush waits at the limit until the slot frees. An i_enable arriving in the flush cycle is accepted as byte 0 of the next word.
- Not defined: no timer is instantiated, o_partial is tied 0, and o_nbytes is always NUM_BYTES when o_valid=1.

Decomposition:
- Package uart_pack_pkg: FSM state encoding (ACC, HOLD), WORD_W derivation helper, and default constants (BYTE_W=8, NUM_BYTES=4, TIMEOUT_CYC=1024).
- One natural sub-module, uart_pack_timer: an idle counter with clear/enable inputs and an expiry output, instantiated only under PACK_TIMEOUT_EN.

Test Plan (BYTE_W=8, NUM_BYTES=4):
- Reset then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with i_ready=1 -> o_word=0x44332211 and o_valid=1 one cycle after the 0x44 strobe, o_nbytes=4, o_partial=0.
- i_ready=0: send 0xA0..0xA3 then 0xB0..0xB3 -> first word held at 0xA3A2A1A0, o_count=4 (HOLD). Raise i_ready one cycle -> o_word becomes 0xB3B2B1B0 with o_valid unbroken.
- In HOLD with i_ready=0, strobe 0xCC -> o_overflow high exactly one cycle, 0xCC absent from all later words.
- In HOLD, i_ready=1 and i_enable=1 with 0x5A in the same cycle -> transfer occurs, o_count=1, and the next word's lane 0 is 0x5A.
- Assert i_rst after 2 bytes with o_valid=1 pending -> next cycle o_valid=0, o_count=0, o_word=0. A following full word packs from lane 0.
- PACK_TIMEOUT_EN, TIMEOUT_CYC=16: send 0x01,0x02 then idle -> after 16 idle cycles o_word=0x00000201, o_nbytes=2, o_partial=1. Without the macro, no output appears.
